// File: rtl/execute_stage_pipe.sv
// execute_stage_pipe: registered execute stage with ALU, branch resolution and iterative shift-add multiplier.
module execute_stage_pipe #(
  parameter int XLEN    = 64,
  parameter int MUL_BPC = 4,
  parameter int RD_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [1:0]      in_alu_op,
  input  logic            in_alu_src,
  input  logic            in_is_mul,
  input  logic            in_branch,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_taken,
  output logic [XLEN-1:0] out_pc_branch,
  output logic [RD_W-1:0] out_rd,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  localparam int NIT = XLEN / MUL_BPC;
  localparam int CW = NIT > 1 ? $clog2(NIT) : 1;
  localparam logic IDLE = 1'b0;
  localparam logic MUL = 1'b1;

  logic            state;
  logic [XLEN-1:0] b, alu_res, pc_br, mcand, mplier, acc, step, acc_nxt, p_pc;
  logic [SW-1:0]   shamt;
  logic [CW-1:0]   cnt;
  logic [RD_W-1:0] p_rd;
  logic            eq, lt, ltu, taken, accept, start, done, p_taken;

  assign busy     = state == MUL;
  assign in_ready = state == IDLE && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign start    = in_is_mul && in_alu_op == 2'b10;
  assign done     = cnt == CW'(NIT - 1);
  assign pc_br    = in_pc + (in_imm << 1);

  always_comb begin
    b = in_alu_src ? in_imm : in_rs2;
    shamt = b[SW-1:0];
    eq = in_rs1 == in_rs2;
    lt = $signed(in_rs1) < $signed(in_rs2);
    ltu = in_rs1 < in_rs2;
    taken = in_branch && (in_funct3 == 3'b000 ? eq :
                          in_funct3 == 3'b001 ? !eq :
                          in_funct3 == 3'b100 ? lt :
                          in_funct3 == 3'b101 ? !lt :
                          in_funct3 == 3'b110 ? ltu :
                          in_funct3 == 3'b111 ? !ltu : 1'b0);
    alu_res = in_rs1 + b;
    if (in_alu_op == 2'b01) alu_res = in_rs1 - in_rs2;
    else if (in_alu_op == 2'b10)
      case (in_funct3)
        3'b000:  alu_res = in_funct7b5 && !in_alu_src ? in_rs1 - b : in_rs1 + b;
        3'b001:  alu_res = in_rs1 << shamt;
        3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_rs1) < $signed(b)};
        3'b011:  alu_res = {{(XLEN-1){1'b0}}, in_rs1 < b};
        3'b100:  alu_res = in_rs1 ^ b;
        3'b101:  alu_res = in_funct7b5 ? XLEN'($signed(in_rs1) >>> shamt) : in_rs1 >> shamt;
        3'b110:  alu_res = in_rs1 | b;
        default: alu_res = in_rs1 & b;
      endcase
  end

  // One radix-2^MUL_BPC digit of the multiplier per cycle
  always_comb begin
    step = '0;
    for (int i = 0; i < MUL_BPC; i++) step = step + (mplier[i] ? mcand << i : '0);
    acc_nxt = acc + step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_result <= '0;
      out_zero <= 1'b0;
      out_taken <= 1'b0;
      out_pc_branch <= '0;
      out_rd <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      p_pc <= '0;
      p_rd <= '0;
      p_taken <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end else if (state == MUL) begin
      acc <= acc_nxt;
      mcand <= mcand << MUL_BPC;
      mplier <= mplier >> MUL_BPC;
      cnt <= cnt + 1'b1;
      if (done) begin
        state <= IDLE;
        out_valid <= 1'b1;
        out_result <= acc_nxt;
        out_zero <= acc_nxt == '0;
        out_taken <= p_taken;
        out_pc_branch <= p_pc;
        out_rd <= p_rd;
      end
    end else if (accept && start) begin
      state <= MUL;
      out_valid <= 1'b0;
      mcand <= in_rs1;
      mplier <= in_rs2;
      acc <= '0;
      cnt <= '0;
      p_pc <= pc_br;
      p_rd <= in_rd;
      p_taken <= taken;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_result <= alu_res;
      out_zero <= alu_res == '0;
      out_taken <= taken;
      out_pc_branch <= pc_br;
      out_rd <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_execute_stage_pipe.sv
// tb_execute_stage_pipe: random and directed stimulus against a transaction-level reference model.
module tb_execute_stage_pipe;
  localparam int NIT = 16;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_alu_src = 1'b0, in_is_mul = 1'b0, in_branch = 1'b0;
  logic        in_funct7b5 = 1'b0, out_valid, out_ready = 1'b1, out_zero, out_taken, busy;
  logic [1:0]  in_alu_op = 2'b00;
  logic [2:0]  in_funct3 = 3'b000;
  logic [4:0]  in_rd = '0, out_rd;
  logic [63:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0, out_result, out_pc_branch;

  typedef struct packed {
    logic [63:0] res;
    logic        zero;
    logic        tk;
    logic [63:0] pcb;
    logic [4:0]  rd;
  } rec_t;

  rec_t m_out, m_pend;
  logic m_ov;
  int   m_rem;
  int   n_cmp = 0, n_bad = 0;

  execute_stage_pipe #(.XLEN(64), .MUL_BPC(4), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_alu_op(in_alu_op), .in_alu_src(in_alu_src), .in_is_mul(in_is_mul),
    .in_branch(in_branch), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_rd(in_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero), .out_taken(out_taken),
    .out_pc_branch(out_pc_branch), .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t ref_op();
    rec_t r;
    logic [63:0] b;
    int sh;
    b = in_alu_src ? in_imm : in_rs2;
    sh = int'(b[5:0]);
    if (in_alu_op == 2'b10 && in_is_mul) r.res = in_rs1 * in_rs2;
    else if (in_alu_op == 2'b01) r.res = in_rs1 - in_rs2;
    else if (in_alu_op != 2'b10) r.res = in_rs1 + b;
    else
      case (in_funct3)
        3'd0: r.res = (in_funct7b5 && !in_alu_src) ? in_rs1 - b : in_rs1 + b;
        3'd1: r.res = in_rs1 << sh;
        3'd2: r.res = 64'($signed(in_rs1) < $signed(b));
        3'd3: r.res = 64'(in_rs1 < b);
        3'd4: r.res = in_rs1 ^ b;
        3'd5: if (in_funct7b5) r.res = $signed(in_rs1) >>> sh; else r.res = in_rs1 >> sh;
        3'd6: r.res = in_rs1 | b;
        default: r.res = in_rs1 & b;
      endcase
    r.zero = r.res == 0;
    case (in_funct3)
      3'd0: r.tk = in_rs1 == in_rs2;
      3'd1: r.tk = in_rs1 != in_rs2;
      3'd4: r.tk = $signed(in_rs1) < $signed(in_rs2);
      3'd5: r.tk = $signed(in_rs1) >= $signed(in_rs2);
      3'd6: r.tk = in_rs1 < in_rs2;
      3'd7: r.tk = in_rs1 >= in_rs2;
      default: r.tk = 1'b0;
    endcase
    r.tk = r.tk && in_branch;
    r.pcb = in_pc + in_imm * 2;
    r.rd = in_rd;
    return r;
  endfunction

  function automatic logic exp_ready();
    return m_rem == 0 && (!m_ov || out_ready) && !flush;
  endfunction

  task automatic model_reset();
    m_ov = 1'b0;
    m_rem = 0;
    m_out = '0;
    m_pend = '0;
  endtask

  // Inputs are stable from negedge; check at +1, advance model on the posedge
  task automatic tick();
    logic acc;
    #1;
    chk("in_ready", in_ready, exp_ready());
    chk("busy", busy, m_rem > 0);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("result", out_result, m_out.res);
      chk("zero", out_zero, m_out.zero);
      chk("taken", out_taken, m_out.tk);
      chk("pc_branch", out_pc_branch, m_out.pcb);
      chk("rd", out_rd, m_out.rd);
    end
    acc = in_valid && exp_ready();
    @(posedge clk);
    if (flush) begin
      m_ov = 1'b0;
      m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_out = m_pend;
        m_ov = 1'b1;
      end
    end else begin
      if (m_ov && out_ready) m_ov = 1'b0;
      if (acc && in_is_mul && in_alu_op == 2'b10) begin
        m_pend = ref_op();
        m_rem = NIT;
      end else if (acc) begin
        m_out = ref_op();
        m_ov = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic src,
                        input logic mul, input logic br, input logic [63:0] a, input logic [63:0] b2,
                        input logic [63:0] imm, input logic [63:0] pc);
    in_valid = 1'b1;
    in_alu_op = op;
    in_funct3 = f3;
    in_funct7b5 = f7;
    in_alu_src = src;
    in_is_mul = mul;
    in_branch = br;
    in_rs1 = a;
    in_rs2 = b2;
    in_imm = imm;
    in_pc = pc;
    in_rd = 5'($urandom);
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(3))
      0: return 64'($urandom_range(15));
      1: return {32'h0, $urandom()};
      2: return -64'($urandom_range(8));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", out_result, 0);
    chk("rst_pc_branch", out_pc_branch, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_flags", {out_zero, out_taken}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd5, 64'd7, 64'd0, 64'h0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("add_result", out_result, 64'd12);
    chk("add_zero", out_zero, 0);
    tick();

    set_op(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1234, 64'h1234, 64'd0, 64'h0);
    tick();
    #1;
    chk("sub_zero", {out_zero, out_result}, {1'b1, 64'd0});
    set_op(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1234, 64'h1234, 64'd8, 64'h100);
    tick();
    #1;
    chk("beq_taken", out_taken, 1);
    chk("beq_target", out_pc_branch, 64'h110);
    set_op(2'b01, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, -64'd1, 64'd1, 64'd4, 64'h200);
    tick();
    #1;
    chk("blt_taken", out_taken, 1);
    set_op(2'b01, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, -64'd1, 64'd1, 64'd4, 64'h200);
    tick();
    #1;
    chk("bltu_taken", out_taken, 0);

    set_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF, 64'd3, 64'd0, 64'h0);
    tick();
    set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 64'd1, 64'd0, 64'h0);
    for (int i = 0; i < NIT; i++) tick();
    #1;
    chk("mul_result", out_result, 64'h2_FFFF_FFFD);
    chk("mul_valid", out_valid, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #1;
    chk("bp_hold", out_result, 64'h2_FFFF_FFFD);
    chk("bp_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();

    set_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 64'd9, 64'd9, 64'd0, 64'h0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_valid", out_valid, 0);
    tick();

    set_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 64'd11, 64'd13, 64'd0, 64'h0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_result", out_result, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int n = 0; n < 1500; n++) begin
      set_op(2'($urandom_range(2)), 3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(7) == 0,
             1'($urandom), rnd_val(), rnd_val(), rnd_val(), {$urandom(), $urandom()});
      if ($urandom_range(3) == 0) in_rs2 = in_rs1;
      in_valid = $urandom_range(3) != 0;
      out_ready = $urandom_range(3) != 0;
      flush = $urandom_range(40) == 0;
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NIT + 2; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
